fifo_rd_stream: RTL and testbench
=================================

# fifo_rd_stream

Read-side drain engine for `async_fifo`. It sits entirely in the `rd_clk` domain and drives the FIFO's `rd_en`. It absorbs the FIFO's one-cycle registered `dout` latency and presents the data as a valid/ready stream with full throughput and no combinational path from `m_ready` to `fifo_rd_en`. A 3-entry internal buffer covers in-flight reads, and a handshake counter supports scoreboarding.

## Interface
- `DATA_W`, default 8: data width; must match the `async_fifo` instance.
- `CNT_W`, default 16: width of the accepted-word counter.

- `rd_clk`  in  1  single clock (the FIFO read clock); all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  when high, the block may issue new FIFO reads.
- `flush`  in  1  synchronous; discards buffered and in-flight words.
- `fifo_empty`  in  1  FIFO `empty`.
- `fifo_rd_en`  out  1  FIFO `rd_en`.
- `fifo_dout`  in  DATA_W  FIFO `dout`; valid in the cycle after a read is accepted.
- `m_valid`  out  1  stream data valid.
- `m_ready`  in  1  stream consumer ready.
- `m_data`  out  DATA_W  stream data (buffer head).
- `rd_count`  out  CNT_W  number of completed `m_valid && m_ready` handshakes.
- `idle`  out  1  high when the buffer is empty and no read is in flight.

## Operation
- State:
  - `rd_pend`: 1-bit register. Set at an edge where `fifo_rd_en` was high; it marks `fifo_dout` as valid during the current cycle.
  - Buffer: 3-entry circular buffer with head/tail pointers (mod 3) and occupancy `occ` (0..3).
- Read issue, combinational: `fifo_rd_en = !rst && en && !flush && !fifo_empty && (occ + rd_pend < 3)`.
- Capture: when `rd_pend` is high and `flush` is low, `fifo_dout` is written at the tail at the next edge and tail advances.
- Pop: when `m_valid && m_ready` and `flush` is low, head advances at the next edge and `rd_count` increments, wrapping from 2^CNT_W-1 to 0.
- Simultaneous capture and pop: `occ` is unchanged and both pointers advance. With `occ==0`, a word captured at edge E is visible on `m_data` after E; a pop in the same edge is impossible because `m_valid` was 0.
- Outputs: `m_valid = (occ != 0)`. `m_data` = entry at head; it is 0 when `occ==0` out of reset and otherwise holds the last head value (don't-care when `m_valid` is low).
- Flush:
  - At the edge where `flush` is high: `occ`, pointers and `rd_pend` are cleared, and the word on `fifo_dout` during that cycle is dropped.
  - `rd_count` is not changed, and no handshake is counted in a flush cycle.
  - `fifo_rd_en` is low throughout `flush`.
- `en` low: no new reads are issued. An in-flight word is still captured, and buffered words still drain to the consumer.
- `idle = (occ==0) && !rd_pend`.
- Overflow is structurally impossible: the issue rule guarantees `occ + rd_pend <= 3`. Verification asserts `occ` never exceeds 3.

## Timing
- Reset values: `fifo_rd_en` 0, `m_valid` 0, `m_data` 0, `rd_count` 0, `idle` 1; `occ`, pointers and `rd_pend` are 0.
- Reset asserted mid-operation: all state clears immediately (asynchronous). An in-flight FIFO word is lost, and the FIFO-side pointer still counts it as read.
- Latency from `fifo_rd_en` sampled high at edge E0 to `m_valid` visible: `rd_pend`=1 after E0, capture at E1, `m_valid`=1 after E1. That is 2 `rd_clk` edges.
- Steady state with `m_ready`=1 and a non-empty FIFO: `occ`=1, `rd_pend`=1, one read and one handshake per cycle, 100% throughput.
- Backpressure (`m_ready`=0): reads stop once `occ + rd_pend` = 3, and `occ` settles at 3. When `m_ready` returns, the first pop happens at the next edge; reading resumes in the cycle after `occ` drops.
- `fifo_empty` deasserting: a read is issued in the same cycle if credit is available.
- `m_data` and `m_valid` are stable while `m_valid && !m_ready`.

## Test plan
- Reset: hold `rst`=1 → `fifo_rd_en`=0, `m_valid`=0, `idle`=1, `rd_count`=0. Release `rst` with `en`=0 → outputs unchanged.
- Streaming: write 0x00..0x0F into `async_fifo`, then `en`=1, `m_ready`=1 → `m_data` sequence is 0x00..0x0F in order. There are no gaps between consecutive `m_valid` cycles once the first word arrives, and `rd_count`=16 at the end.
- Backpressure: 16 words, `m_ready`=0 → exactly 3 `fifo_rd_en` pulses, `occ`=3, `m_data`=0x00 held stable. Then `m_ready`=1 → remaining 13 words arrive in order and `rd_count`=16.
- Random `m_ready` (50%) with a random write rate → scoreboard matches every word, and `occ` never exceeds 3.
- Flush: with `occ`=3 and `rd_pend`=0, pulse `flush` for one cycle → `m_valid`=0, `idle`=1, `rd_count` unchanged. The next word delivered is the 4th word written (0x03).
- Counter wrap with `CNT_W`=4: 17 handshakes → `rd_count`=1.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains an async_fifo read port into a valid/ready stream.
// A 3-entry skid buffer absorbs the FIFO's registered dout latency, so reads
// are issued from buffer credit only and m_ready never reaches fifo_rd_en.
module fifo_rd_stream #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              rd_clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CNT_W-1:0]  rd_count,
  output logic              idle
);

  logic [DATA_W-1:0] mem [3];
  logic [1:0]        head;
  logic [1:0]        tail;
  logic [1:0]        occ;
  logic              rd_pend;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        credit_used;
  logic              cap;
  logic              pop;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A word in flight already owns a buffer slot, so both count against credit.
  assign credit_used = {1'b0, occ} + {2'b00, rd_pend};
  assign fifo_rd_en  = !rst && en && !flush && !fifo_empty && (credit_used < 3'd3);

  assign m_valid  = (occ != 2'd0);
  assign m_data   = mem[head];
  assign rd_count = cnt;
  assign idle     = (occ == 2'd0) && !rd_pend;

  assign cap = rd_pend && !flush;
  assign pop = m_valid && m_ready && !flush;

  // Pointers, occupancy, in-flight flag and handshake counter.
  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      head    <= 2'd0;
      tail    <= 2'd0;
      occ     <= 2'd0;
      rd_pend <= 1'b0;
      cnt     <= '0;
    end else if (flush) begin
      head    <= 2'd0;
      tail    <= 2'd0;
      occ     <= 2'd0;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= fifo_rd_en;
      if (cap) tail <= next_ptr(tail);
      if (pop) begin
        head <= next_ptr(head);
        cnt  <= cnt + 1'b1;
      end
      case ({cap, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Buffer storage; cleared on reset so m_data reads 0 out of reset.
  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) mem[i] <= '0;
    end else if (cap) begin
      mem[tail] <= fifo_dout;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: models the FIFO as a queue with registered dout,
// and the stream side as a queue-based buffer plus an in-flight flag.
module tb_fifo_rd_stream;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  logic              rd_clk = 1'b0;
  logic              rst;
  logic              en;
  logic              flush;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_dout;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [CNT_W-1:0]  rd_count;
  logic              idle;

  fifo_rd_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .rd_clk(rd_clk), .rst(rst), .en(en), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .rd_count(rd_count), .idle(idle)
  );

  always #5 rd_clk = ~rd_clk;

  // Reference model state
  logic [7:0]  fq[$];
  logic [7:0]  bq[$];
  bit          inflight;
  logic [7:0]  inflight_w;
  int unsigned hs_total;
  logic [7:0]  next_wr;

  // Observations
  int          checks = 0;
  int          errors = 0;
  int          rd_pulses;
  logic [7:0]  obs_last;
  logic [7:0]  obs_first;
  bit          want_first;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      fq.push_back(next_wr);
      next_wr++;
    end
  endtask

  // One rd_clk cycle: check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle(input bit do_wr);
    bit e_rd, e_valid, hs, cap;
    fifo_empty = (fq.size() == 0);
    #1;
    e_rd    = en && !flush && (fq.size() != 0) && ((bq.size() + int'(inflight)) < 3);
    e_valid = (bq.size() != 0);
    chk("rd_en", 32'(fifo_rd_en), 32'(e_rd));
    chk("m_valid", 32'(m_valid), 32'(e_valid));
    chk("idle", 32'(idle), 32'(!e_valid && !inflight));
    chk("rd_count", 32'(rd_count), hs_total % 16);
    if (e_valid) chk("m_data", 32'(m_data), 32'(bq[0]));
    if (fifo_rd_en) rd_pulses++;
    hs = m_valid && m_ready && !flush;
    if (hs) begin
      obs_last = m_data;
      if (want_first) begin
        obs_first  = m_data;
        want_first = 0;
      end
    end
    @(posedge rd_clk);
    cap = inflight && !flush;
    if (flush) begin
      bq.delete();
      inflight = 0;
    end else begin
      if (e_valid && m_ready) begin
        void'(bq.pop_front());
        hs_total++;
      end
      if (cap) bq.push_back(inflight_w);
      inflight = e_rd;
      if (e_rd) inflight_w = fq.pop_front();
    end
    if (do_wr) push_words(1);
    #1;
    fifo_dout  = inflight ? inflight_w : 8'($urandom);
    fifo_empty = (fq.size() == 0);
    @(negedge rd_clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; m_ready = 1'b0;
    fifo_dout = '0; fifo_empty = 1'b1;
    inflight = 0; hs_total = 0; next_wr = 0; rd_pulses = 0;
    obs_last = 0; obs_first = 0; want_first = 0; inflight_w = 0;

    // Reset values
    repeat (2) @(negedge rd_clk);
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_idle", 32'(idle), 1);
    chk("rst_rd_count", 32'(rd_count), 0);
    rst = 1'b0;
    push_words(4);
    run(3);
    chk("rel_m_data", 32'(m_data), 0);
    fq.delete();

    // Streaming, full throughput
    next_wr = 0;
    push_words(16);
    en = 1'b1; m_ready = 1'b1;
    run(22);
    chk("stream_last", 32'(obs_last), 32'h0F);

    // Backpressure
    next_wr = 0;
    m_ready = 1'b0;
    push_words(16);
    rd_pulses = 0;
    run(8);
    chk("bp_pulses", 32'(rd_pulses), 3);
    chk("bp_hold", 32'(m_data), 32'h00);
    m_ready = 1'b1;
    run(22);
    chk("bp_last", 32'(obs_last), 32'h0F);

    // Flush with a full buffer and nothing in flight
    next_wr = 0;
    m_ready = 1'b0;
    push_words(16);
    run(8);
    flush = 1'b1;
    cycle(1'b0);
    flush = 1'b0;
    chk("flush_valid", 32'(m_valid), 0);
    chk("flush_idle", 32'(idle), 1);
    want_first = 1;
    m_ready = 1'b1;
    run(22);
    chk("flush_first", 32'(obs_first), 32'h03);

    // Asynchronous reset mid-stream
    next_wr = 0;
    push_words(16);
    run(4);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(m_valid), 0);
    chk("mid_rst_idle", 32'(idle), 1);
    chk("mid_rst_rd_en", 32'(fifo_rd_en), 0);
    chk("mid_rst_count", 32'(rd_count), 0);
    bq.delete(); inflight = 0; hs_total = 0;
    fq.delete();
    @(negedge rd_clk);
    rst = 1'b0;

    // Counter wrap: 17 handshakes on a 4-bit counter
    next_wr = 8'h40;
    push_words(17);
    run(24);
    chk("wrap_count", 32'(rd_count), 1);

    // Random backpressure, write rate, enable and occasional flush
    for (int i = 0; i < 800; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      en      = ($urandom_range(0, 7) != 0);
      flush   = ($urandom_range(0, 59) == 0);
      cycle($urandom_range(0, 2) != 0);
    end
    flush = 1'b0; en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 1000 && (fq.size() != 0 || bq.size() != 0 || inflight); i++)
      cycle(1'b0);
    chk("drain_done", 32'(fq.size() + bq.size() + int'(inflight)), 0);
    run(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
